// File: rtl/alu_result_stage.sv
// Registered ALU result stage: NZCV flag generation and a 2-entry skid buffer over valid/ready.
// Optional sticky overflow enabled by defining ALU_STICKY_OVF_EN.
module alu_result_stage #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] RESULT,
  input  logic [3:0]   SELECTOR,
  input  logic         C_IN,
  input  logic         V_IN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] OUT_RESULT,
  output logic [3:0]   OUT_FLAGS,
  output logic [3:0]   OUT_SEL,
  output logic         STICKY_V,
  input  logic         CLR_STICKY
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [N-1:0]   out_res_q;
  logic [3:0]     out_flags_q;
  logic [3:0]     out_sel_q;
  logic [N-1:0]   skid_res_q;
  logic [3:0]     skid_flags_q;
  logic [3:0]     skid_sel_q;
  logic           run_c_q;
  logic           run_v_q;

  logic           accept;
  logic           pop;
  logic           arith;
  logic           c_d;
  logic           v_d;
  logic [3:0]     flags_d;

  // Only the add/sub opcodes produce a fresh carry/overflow; everything else inherits the running pair.
  always_comb begin
    accept  = IN_VALID && in_ready_q;
    pop     = out_valid_q && OUT_READY;
    arith   = (SELECTOR == 4'b0000) || (SELECTOR == 4'b0001);
    c_d     = arith ? C_IN : run_c_q;
    v_d     = arith ? V_IN : run_v_q;
    flags_d = {RESULT[N-1], (RESULT == {N{1'b0}}), c_d, v_d};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_res_q    <= '0;
      out_flags_q  <= '0;
      out_sel_q    <= '0;
      skid_res_q   <= '0;
      skid_flags_q <= '0;
      skid_sel_q   <= '0;
      run_c_q      <= 1'b0;
      run_v_q      <= 1'b0;
    end else begin
      if (accept) begin
        run_c_q <= c_d;
        run_v_q <= v_d;
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_res_q   <= RESULT;
            out_flags_q <= flags_d;
            out_sel_q   <= SELECTOR;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            out_res_q   <= RESULT;
            out_flags_q <= flags_d;
            out_sel_q   <= SELECTOR;
          end else if (accept) begin
            skid_res_q   <= RESULT;
            skid_flags_q <= flags_d;
            skid_sel_q   <= SELECTOR;
            in_ready_q   <= 1'b0;
            state_q      <= FULL;
          end else if (pop) begin
            // Output registers keep the popped entry visible while idle.
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out_res_q   <= skid_res_q;
            out_flags_q <= skid_flags_q;
            out_sel_q   <= skid_sel_q;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY   = in_ready_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_RESULT = out_res_q;
  assign OUT_FLAGS  = out_flags_q;
  assign OUT_SEL    = out_sel_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  // Set has priority so an overflow coinciding with a clear is never lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sticky_q <= 1'b0;
    end else if (accept && flags_d[0]) begin
      sticky_q <= 1'b1;
    end else if (CLR_STICKY) begin
      sticky_q <= 1'b0;
    end
  end

  assign STICKY_V = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = CLR_STICKY;
  assign STICKY_V          = 1'b0;
`endif

endmodule
